fc_layer_argmax: RTL and testbench
==================================

# fc_layer_argmax

Parametrised fully connected layer that computes all output neuron scores and the predicted class in one block. Pixels arrive on a strobe from an external clock domain; the block synchronises the strobe and accumulates signed weight × pixel products across LANES parallel MAC lanes. After the last pixel it adds per-neuron bias with saturation, runs an argmax scan, and presents the class index with a one-cycle valid pulse. It is the next-generation replacement for the single-MAC `nn` core and sits between the pixel capture logic and the result register bank.

## Interface
- BITS, 24: pixel, weight, bias and score width. Pixels are unsigned Q.FRAC; weights, bias and score are signed Q.FRAC.
- FRAC, 12: fractional bits (4096 = 1.0).
- WIDTH, 784: pixels per frame.
- HEIGHT, 10: output neurons.
- LANES, 2: parallel MAC lanes; 1 ≤ LANES ≤ HEIGHT.
- SYNC_STAGES, 2: synchroniser flops on new_data, minimum 2.
- Derived parameters:
  - CW = $clog2(WIDTH)
  - IW = $clog2(HEIGHT)
  - ACC_W = 2*BITS + CW
  - PASSES = ceil(HEIGHT/LANES)
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- new_data  in  1  asynchronous pixel strobe; a rising edge marks nn_in valid.
- nn_in  in  BITS  pixel value; stable from before the new_data edge until busy falls.
- wr_en  in  1  weight/bias write strobe.
- wr_addr  in  $clog2(HEIGHT*WIDTH+HEIGHT)  address.
  - Below HEIGHT*WIDTH: weight at neuron*WIDTH + pixel.
  - Otherwise: bias[wr_addr − HEIGHT*WIDTH].
- wr_data  in  BITS  signed weight or bias.
- CNT_out  out  CW  count of pixels accepted in the current frame.
- nn_out  out  IW  predicted class, held until the next result.
- score_out  out  BITS  saturated score of nn_out.
- valid  out  1  one-cycle pulse when nn_out/score_out update.
- busy  out  1  high while not IDLE.
- overrun  out  1  sticky; set when a strobe arrives while busy.
- acc0_out  out  ACC_W  debug view of the neuron 0 accumulator.

## Operation
- Strobe path:
  - new_data passes through SYNC_STAGES flops.
  - en = (last stage high) & (extra delay flop low), giving one pulse per rising edge regardless of how long new_data stays high.
- Weight storage:
  - LANES banks; neuron n is stored in bank n % LANES at row (n / LANES)*WIDTH + pixel.
  - Bias is held in a separate HEIGHT-entry register file.
  - Writes are accepted only in IDLE; writes in any other state are dropped.
  - reset does not clear weight or bias storage.
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
  - IDLE: on en, latch nn_in and go to ACCUM with pass = 0.
  - ACCUM: each cycle, lane l adds pixel × w[pass*LANES + l] to its neuron's accumulator. Lanes whose index is ≥ HEIGHT are masked.
  - When ACCUM finishes pass PASSES−1, CNT_out increments. If the new count equals WIDTH, go to ARGMAX; otherwise return to IDLE.
  - ARGMAX: one neuron per cycle, index 0 to HEIGHT−1.
    - score = sat_BITS((acc >>> FRAC) + bias), arithmetic shift.
    - Replace the best entry only on strictly greater, so a tie keeps the lowest index.
  - DONE: update nn_out and score_out, pulse valid, clear all accumulators and CNT_out, then go to IDLE.
- Arithmetic:
  - Product = {1'b0, pixel} × signed weight, sign-extended to ACC_W.
  - The accumulator does not wrap within ACC_W.
  - Saturation bounds are −2^(BITS−1) and 2^(BITS−1) − 1.
- Overrun:
  - en seen in ACCUM, ARGMAX or DONE sets overrun and the pixel is ignored.
  - Only reset clears overrun.
- Reset at any point:
  - State goes to IDLE; accumulators, CNT_out, pass, nn_out, score_out, valid, overrun, busy and the synchroniser flops clear to 0.
  - A partially accumulated frame is discarded.

## Timing
- A new_data rising edge reaches en SYNC_STAGES to SYNC_STAGES+1 cycles later (edge detection needs 1 extra flop).
- Per pixel, busy is high for PASSES cycles; with defaults, 5 cycles.
- Minimum strobe spacing: SYNC_STAGES + PASSES + 1 cycles.
- Last pixel en to valid: PASSES + HEIGHT + 1 cycles.
- valid is high for exactly 1 cycle.
- busy falls in the cycle after valid.
- Simultaneous wr_en and en in IDLE: the write completes and the pixel is accepted. The written weight is visible to that pixel only if its address is in pass ≥ 1.
- Reset values of all outputs are 0.

## Test plan
- Class select:
  - Stimulus: neuron 3 weights = 4096 for all pixels, every other weight and every bias = 0, all 784 pixels = 4096.
  - Required: nn_out = 3, score_out = 3211264, valid pulses once, CNT_out returns to 0.
- Tie:
  - Stimulus: neurons 2 and 7 have identical weights = 1000, all pixels = 4096.
  - Required: nn_out = 2.
- Saturation and negative scores:
  - Stimulus: frame 1 uses the class-select setup with bias[3] = 8000000. Frame 2 sets all weights to −4096 and bias[5] = 100.
  - Required: frame 1 gives score_out = 8388607. Frame 2 gives nn_out = 5 and score_out = −3211164.
- Strobe and overrun:
  - Stimulus: new_data held high for 40 cycles. Then a second edge 2 cycles after an accepted one.
  - Required: the held strobe advances CNT_out by 1. The second edge sets overrun and CNT_out does not advance.
- Reset mid-frame:
  - Stimulus: assert reset for 1 cycle after 100 pixels, then run the full class-select frame.
  - Required: all outputs go to 0 after reset, weights are retained, and the following frame gives nn_out = 3.
- Parameter sweep:
  - Stimulus: LANES = 1, 3 and 10 with the class-select frame.
  - Required: results are identical; valid arrives PASSES + HEIGHT + 1 cycles after the last en.

Source files
------------

// File: rtl/fc_layer_argmax.sv
`timescale 1ns/1ps
// fc_layer_argmax
// Fully connected layer with built-in argmax. Pixels arrive on an asynchronous
// strobe. Each pixel is multiplied against every neuron's weight using LANES
// parallel MAC lanes, over PASSES cycles. After WIDTH pixels, each neuron score
// is computed as sat((acc >>> FRAC) + bias). A linear scan then picks the
// highest score, and the lowest index wins a tie.
//
// Ports
//   clk, reset  single clock, synchronous active-high reset
//   new_data    asynchronous pixel strobe (rising edge = nn_in valid)
//   nn_in       unsigned Q.FRAC pixel
//   wr_en/wr_addr/wr_data  weight (addr < HEIGHT*WIDTH) or bias write, IDLE only
//   CNT_out     pixels accepted in the current frame
//   nn_out      predicted class; score_out is its saturated score
//   valid       one-cycle pulse when nn_out/score_out update
//   busy        high while not IDLE
//   overrun     sticky, set by a strobe that arrives while busy
//   acc0_out    neuron 0 accumulator (debug)
module fc_layer_argmax #(
  parameter int BITS        = 24,
  parameter int FRAC        = 12,
  parameter int WIDTH       = 784,
  parameter int HEIGHT      = 10,
  parameter int LANES       = 2,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(WIDTH),
  localparam int IW         = $clog2(HEIGHT),
  localparam int ACC_W      = 2 * BITS + CW,
  localparam int AW         = $clog2(HEIGHT * WIDTH + HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_data,
  input  logic [BITS-1:0]  nn_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BITS-1:0]  wr_data,
  output logic [CW-1:0]    CNT_out,
  output logic [IW-1:0]    nn_out,
  output logic [BITS-1:0]  score_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic [ACC_W-1:0] acc0_out
);

  localparam int PASSES = (HEIGHT + LANES - 1) / LANES;
  localparam int DEPTH  = PASSES * WIDTH;
  localparam int RW     = $clog2(DEPTH);
  localparam int PW     = $clog2(PASSES + 1);
  localparam int NW     = HEIGHT * WIDTH;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-BITS+1){1'b1}}, {(BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    dly_q, dly_d;
  logic                    en;
  logic [BITS-1:0]         pix_q, pix_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [HEIGHT];
  logic signed [ACC_W-1:0] acc_d [HEIGHT];
  logic signed [BITS-1:0]  best_q, best_d;
  logic [IW-1:0]           best_idx_q, best_idx_d;
  logic [IW-1:0]           nn_out_q, nn_out_d;
  logic [BITS-1:0]         score_q, score_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  // Storage: LANES weight banks plus a bias register file.
  logic signed [BITS-1:0]  w_mem [LANES][DEPTH];
  logic signed [BITS-1:0]  bias_mem [HEIGHT];
  logic signed [BITS-1:0]  w_rd_q [LANES];

  int                      wa, wn, wp, w_bank, rd_pass;
  logic                    w_we, b_we;
  logic [RW-1:0]           w_row, rd_row;
  logic [IW-1:0]           b_idx;
  logic signed [ACC_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0] sum;
  logic signed [BITS-1:0]  cur_score;
  logic                    take;

  // The strobe comes from another domain. The last stage AND NOT the delay
  // flop gives one en pulse per rising edge, however long the strobe stays high.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], new_data};
  assign dly_d  = sync_q[SYNC_STAGES-1];
  assign en     = sync_q[SYNC_STAGES-1] & ~dly_q;

  // Address decode. Neuron n lives in bank n % LANES at row (n / LANES)*WIDTH + pixel.
  // The weight for pass p is read one cycle early (in IDLE for pass 0), so the
  // read register captures the pre-write value when a write and en coincide.
  always_comb begin
    wa      = int'(wr_addr);
    wn      = wa / WIDTH;
    wp      = wa % WIDTH;
    w_bank  = wn % LANES;
    w_row   = RW'((wn / LANES) * WIDTH + wp);
    b_idx   = IW'(wa - NW);
    w_we    = wr_en && (state_q == IDLE) && (wa < NW);
    b_we    = wr_en && (state_q == IDLE) && (wa >= NW) && (wa < NW + HEIGHT);
    rd_pass = (state_q == IDLE) ? 0 : int'(pass_q) + 1;
    if (rd_pass >= PASSES) rd_pass = 0;
    rd_row  = RW'(rd_pass * WIDTH + int'(cnt_q));
  end

  // NOTE: storage arrays have no reset on purpose. Reset must keep the loaded
  // weights, and a resettable array cannot map onto RAM.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_bank == l) w_mem[l][w_row] <= wr_data;
      end
    end
    if (b_we) bias_mem[b_idx] <= wr_data;
    for (int l = 0; l < LANES; l++) w_rd_q[l] <= w_mem[l][rd_row];
  end

  // The pixel is zero-extended to make it non-negative, then sign-extended with the weight.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = ACC_W'($signed({1'b0, pix_q})) * ACC_W'(w_rd_q[l]);
    end
  end

  // Score of the neuron under scan, with an arithmetic shift and saturation to BITS.
  always_comb begin
    sum = (acc_q[idx_q] >>> FRAC) + ACC_W'(bias_mem[idx_q]);
    if (sum > SAT_MAX)      cur_score = SAT_MAX[BITS-1:0];
    else if (sum < SAT_MIN) cur_score = SAT_MIN[BITS-1:0];
    else                    cur_score = sum[BITS-1:0];
    // A strictly greater score is required, so a tie keeps the lower index.
    take = (idx_q == '0) || (cur_score > best_q);
  end

  // NOTE: every signal gets a default before the case statement. That way no
  // path leaves a value unassigned, and no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    nn_out_d   = nn_out_q;
    score_d    = score_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;

    if (en && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (en) begin
          pix_d   = nn_in;
          pass_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Lanes whose neuron index would be >= HEIGHT have no acc to update.
        for (int n = 0; n < HEIGHT; n++) begin
          if ((n / LANES) == int'(pass_q)) acc_d[n] = acc_q[n] + prod[n % LANES];
        end
        if (int'(pass_q) == PASSES - 1) begin
          pass_d = '0;
          cnt_d  = cnt_q + 1'b1;
          if (int'(cnt_q) == WIDTH - 1) begin
            idx_d   = '0;
            state_d = ARGMAX;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pass_d = pass_q + 1'b1;
        end
      end
      ARGMAX: begin
        if (take) begin
          best_d     = cur_score;
          best_idx_d = idx_q;
        end
        if (int'(idx_q) == HEIGHT - 1) begin
          // The result registers load here, so they are visible during DONE.
          nn_out_d = take ? idx_q : best_idx_q;
          score_d  = take ? cur_score : best_q;
          valid_d  = 1'b1;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        for (int n = 0; n < HEIGHT; n++) acc_d[n] = '0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses only non-blocking assignments. All flops then
  // update together, and the order of the statements does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      dly_q      <= 1'b0;
      pix_q      <= '0;
      pass_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      for (int n = 0; n < HEIGHT; n++) acc_q[n] <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      nn_out_q   <= '0;
      score_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      dly_q      <= dly_d;
      pix_q      <= pix_d;
      pass_q     <= pass_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      nn_out_q   <= nn_out_d;
      score_q    <= score_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign CNT_out   = cnt_q;
  assign nn_out    = nn_out_q;
  assign score_out = score_q;
  assign valid     = valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign acc0_out  = acc_q[0];

endmodule

// File: tb/tb_fc_layer_argmax.sv
`timescale 1ns/1ps
// tb_fc_layer_argmax
// Drives four instances of fc_layer_argmax with LANES = 2, 1, 3 and 10 from
// shared inputs. Instance 0 (LANES = 2) sees every pixel strobe. The other
// three see strobes only while sweep_on is high, so they run the class-select
// frame alongside instance 0 and must give identical results.
module tb_fc_layer_argmax;

  localparam int BITS   = 24;
  localparam int WIDTH  = 784;
  localparam int HEIGHT = 10;
  localparam int NW     = WIDTH * HEIGHT;
  localparam int SYNC   = 2;
  localparam int NDUT   = 4;
  localparam int CW     = 10;
  localparam int IW     = 4;
  localparam int ACC_W  = 58;
  localparam int AW     = 13;

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 10;
    endcase
  endfunction

  logic             clk = 1'b0;
  logic             reset, new_data, sweep_on, wr_en;
  logic [BITS-1:0]  nn_in, wr_data;
  logic [AW-1:0]    wr_addr;
  logic [NDUT-1:0]  nd_v, valid_v, busy_v, ovr_v;
  logic [CW-1:0]    cnt_v   [NDUT];
  logic [IW-1:0]    nn_v    [NDUT];
  logic [BITS-1:0]  score_v [NDUT];
  logic [ACC_W-1:0] acc0_v  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign nd_v[g] = (g == 0) ? new_data : (new_data & sweep_on);
    fc_layer_argmax #(.LANES(lanes_of(g))) u_dut (
      .clk      (clk),
      .reset    (reset),
      .new_data (nd_v[g]),
      .nn_in    (nn_in),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .CNT_out  (cnt_v[g]),
      .nn_out   (nn_v[g]),
      .score_out(score_v[g]),
      .valid    (valid_v[g]),
      .busy     (busy_v[g]),
      .overrun  (ovr_v[g]),
      .acc0_out (acc0_v[g])
    );
  end

  // Cycle counter and valid monitor. vtotal counts the high cycles of valid,
  // and vcyc records the cycle in which valid was last seen.
  int cyc = 0;
  int vtotal [NDUT] = '{default: 0};
  int vcyc   [NDUT] = '{default: 0};
  int rise_cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (valid_v[g]) begin
        vtotal[g] <= vtotal[g] + 1;
        vcyc[g]   <= cyc;
      end
    end
  end

  typedef struct {
    string  tag;
    int     setup;
    bit     sweep;
    int     exp_nn;
    int     exp_score;
    longint exp_acc0;
  } vec_t;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = BITS'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic set_neuron(input int n, input int w);
    for (int p = 0; p < WIDTH; p++) wr(n * WIDTH + p, w);
  endtask

  task automatic pulse(input int hi, input int lo);
    new_data = 1'b1;
    repeat (hi) @(negedge clk);
    new_data = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic run_pixels(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      rise_cyc = cyc;
      pulse(3, period - 3);
    end
  endtask

  task automatic do_setup(input int id);
    case (id)
      0: begin
        for (int n = 0; n < HEIGHT; n++) set_neuron(n, (n == 3) ? 4096 : 0);
        for (int n = 0; n < HEIGHT; n++) wr(NW + n, 0);
      end
      1: wr(NW + 3, 8000000);
      2: begin
        wr(NW + 3, 0);
        set_neuron(3, 0);
        set_neuron(2, 1000);
        set_neuron(7, 1000);
      end
      default: begin
        for (int n = 0; n < HEIGHT; n++) set_neuron(n, -4096);
        wr(NW + 5, 100);
      end
    endcase
  endtask

  // Runs one full frame of pixels (all = 4096). It then checks the result,
  // the single valid pulse, and the latency from the last strobe edge to valid:
  // SYNC cycles to en, then PASSES + HEIGHT + 1 cycles to valid.
  task automatic run_frame(input string tag, input bit sweep, input int exp_nn,
                           input int exp_score, input longint exp_acc0);
    int  period;
    int  snap [NDUT];
    bit  done;
    int  passes;
    period   = sweep ? 14 : 9;
    sweep_on = sweep;
    for (int g = 0; g < NDUT; g++) snap[g] = vtotal[g];
    run_pixels(100, period);
    check($sformatf("%s CNT@100", tag), cnt_v[0], 100);
    check($sformatf("%s acc0@100", tag), $signed(acc0_v[0]), exp_acc0);
    run_pixels(WIDTH - 100, period);
    for (int k = 0; k < 80; k++) begin
      done = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if ((g == 0 || sweep) && vtotal[g] == snap[g]) done = 1'b0;
      end
      if (done) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    sweep_on = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      if (g == 0 || sweep) begin
        passes = (HEIGHT + lanes_of(g) - 1) / lanes_of(g);
        check($sformatf("%s L%0d nn_out", tag, lanes_of(g)), nn_v[g], exp_nn);
        check($sformatf("%s L%0d score_out", tag, lanes_of(g)), $signed(score_v[g]), exp_score);
        check($sformatf("%s L%0d valid cycles", tag, lanes_of(g)), vtotal[g] - snap[g], 1);
        check($sformatf("%s L%0d latency", tag, lanes_of(g)), vcyc[g] - rise_cyc,
              SYNC + passes + HEIGHT + 1);
        check($sformatf("%s L%0d CNT after", tag, lanes_of(g)), cnt_v[g], 0);
        check($sformatf("%s L%0d busy after", tag, lanes_of(g)), busy_v[g], 0);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag, input int g);
    check($sformatf("%s CNT_out", tag), cnt_v[g], 0);
    check($sformatf("%s nn_out", tag), nn_v[g], 0);
    check($sformatf("%s score_out", tag), score_v[g], 0);
    check($sformatf("%s valid", tag), valid_v[g], 0);
    check($sformatf("%s busy", tag), busy_v[g], 0);
    check($sformatf("%s overrun", tag), ovr_v[g], 0);
    check($sformatf("%s acc0_out", tag), acc0_v[g], 0);
  endtask

  // Strobe handling, overrun and a mid-frame reset on instance 0.
  task automatic strobe_reset_seq();
    check("overrun clean after frame", ovr_v[0], 0);
    pulse(40, 10);
    check("held strobe CNT", cnt_v[0], 1);
    check("held strobe overrun", ovr_v[0], 0);
    // Second rising edge two cycles after an accepted one.
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    @(negedge clk);
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    repeat (10) @(negedge clk);
    check("double edge CNT", cnt_v[0], 2);
    check("double edge overrun", ovr_v[0], 1);
    run_pixels(98, 9);
    check("pre-reset CNT", cnt_v[0], 100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("mid reset", 0);
    run_frame("after reset", 1'b0, 3, 3211264, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    vecs[0] = '{"class select", 0, 1'b1, 3, 3211264, 0};
    vecs[1] = '{"saturate", 1, 1'b0, 3, 8388607, 0};
    vecs[2] = '{"tie", 2, 1'b0, 2, 784000, 0};
    vecs[3] = '{"negative", 3, 1'b0, 5, -3211164, -1677721600};

    reset    = 1'b1;
    new_data = 1'b0;
    sweep_on = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    nn_in    = 24'd4096;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check_zero_outputs($sformatf("reset L%0d", lanes_of(g)), g);

    for (int i = 0; i < 4; i++) begin
      if (i == 1) strobe_reset_seq();
      do_setup(vecs[i].setup);
      run_frame(vecs[i].tag, vecs[i].sweep, vecs[i].exp_nn, vecs[i].exp_score, vecs[i].exp_acc0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
